// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, line idle level and
// default bit timing shared by the transmitter and the future receiver.
package uart_pkg;

    // Transmitter frame sequencing states
    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

    // A UART line rests at logic high between frames
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // 100 MHz system clock at 115200 baud
    localparam int unsigned UART_CLKS_PER_BIT = 868;

    // Wide enough for any bit period up to 65535 clocks
    localparam int unsigned UART_CNT_WIDTH = 16;

    // Width of an index that walks 0..n-1; never narrower than one bit
    function automatic int unsigned uart_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps. The tick output
// marks the last clock of a bit period; pre_tick marks the clock before it
// so that registered outputs can be aligned with that last clock.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned CNT_WIDTH    = UART_CNT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick,
    output logic pre_tick
);

    localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [CNT_WIDTH-1:0] PRE_COUNT  = CNT_WIDTH'(CLKS_PER_BIT - 2);

    logic [CNT_WIDTH-1:0] count;

    assign tick     = (count == LAST_COUNT);
    assign pre_tick = (count == PRE_COUNT);

    // Free-running period counter; clear pins it at zero so the first
    // period after clear is always a full CLKS_PER_BIT clocks long
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART 8N1 transmitter fed from the TX FIFO read port. Pops one word per
// frame, sends start bit, DATA_WIDTH data bits LSB first and a stop bit,
// and drains the FIFO back to back with a two-clock gap (POP, LOAD).
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned CNT_WIDTH    = UART_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_read_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned         IDX_W    = uart_idx_width(DATA_WIDTH);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    uart_tx_state_t        state;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [IDX_W-1:0]      bit_idx;
    logic                  cnt_clear;
    logic                  tick;
    logic                  pre_tick;

    // The counter only times START/DATA/STOP; holding it cleared through
    // IDLE, POP and LOAD means START always begins with a full bit period.
    // Bit boundaries inside a frame reuse the counter's own wrap.
    assign cnt_clear  = (state == IDLE) || (state == POP) || (state == LOAD);
    assign shift_next = shift >> 1;

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_baud_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    // Frame sequencer; every output is a register updated on the same edge
    // as the state it belongs to, so tx changes exactly on state entry
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            tx           <= UART_IDLE_LEVEL;
            busy         <= 1'b0;
            fifo_read_en <= 1'b0;
            frame_done   <= 1'b0;
            shift        <= '0;
            bit_idx      <= '0;
        end else begin
            // Both strobes are single-cycle unless a state re-asserts them
            fifo_read_en <= 1'b0;
            frame_done   <= 1'b0;

            case (state)
                IDLE: begin
                    tx <= UART_IDLE_LEVEL;
                    if (!fifo_empty) begin
                        state        <= POP;
                        fifo_read_en <= 1'b1;
                        busy         <= 1'b1;
                    end
                end

                // The pop strobe is visible during this cycle; the FIFO
                // presents the word during LOAD
                POP: begin
                    state <= LOAD;
                end

                LOAD: begin
                    shift   <= fifo_data;
                    bit_idx <= '0;
                    tx      <= 1'b0;
                    state   <= START;
                end

                START: begin
                    if (tick) begin
                        tx    <= shift[0];
                        state <= DATA;
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_IDX) begin
                            tx    <= UART_IDLE_LEVEL;
                            state <= STOP;
                        end else begin
                            shift   <= shift_next;
                            tx      <= shift_next[0];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end

                STOP: begin
                    // Raised one clock early so the registered pulse lands
                    // on the final clock of the stop bit
                    if (pre_tick) begin
                        frame_done <= 1'b1;
                    end
                    // FIFO state is sampled at the stop exit, so a word
                    // written during the stop bit is picked up immediately
                    if (tick) begin
                        if (!fifo_empty) begin
                            state        <= POP;
                            fifo_read_en <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    tx    <= UART_IDLE_LEVEL;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (4 and 2 clocks per bit), each fed by a
// small FIFO model, with the serial output logged per clock and compared to
// a waveform computed directly from the frame format and timing rules.
module tb_uart_tx;

    localparam int CA   = 4;
    localparam int CB   = 2;
    localparam int LOGN = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b0;
    logic rst_b = 1'b0;

    int cyc = 0;
    int passed = 0;
    int total = 0;

    // FIFO models feeding each DUT
    logic [7:0] mem_a [0:31];
    logic [7:0] mem_b [0:31];
    int         wp_a = 0, rp_a = 0, wp_b = 0, rp_b = 0;
    logic       wr_en_a = 1'b0, wr_en_b = 1'b0;
    logic [7:0] wr_data_a = '0, wr_data_b = '0;
    logic [7:0] fifo_data_a = '0, fifo_data_b = '0;
    logic       fifo_empty_a, fifo_empty_b;
    logic       rd_a, tx_a, busy_a, done_a;
    logic       rd_b, tx_b, busy_b, done_b;

    assign fifo_empty_a = (wp_a == rp_a);
    assign fifo_empty_b = (wp_b == rp_b);

    // Per-clock record of {tx, fifo_read_en, frame_done, busy}
    logic [3:0] log_a [0:LOGN-1];
    logic [3:0] log_b [0:LOGN-1];

    // Frame contents for the burst currently being checked
    logic [7:0] burst [0:15];

    uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CA), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst_a), .fifo_data(fifo_data_a), .fifo_empty(fifo_empty_a),
        .fifo_read_en(rd_a), .tx(tx_a), .busy(busy_a), .frame_done(done_a)
    );

    uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CB), .CNT_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst_b), .fifo_data(fifo_data_b), .fifo_empty(fifo_empty_b),
        .fifo_read_en(rd_b), .tx(tx_b), .busy(busy_b), .frame_done(done_b)
    );

    // Cycle counter and synchronous FIFOs (data valid the clock after a pop)
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wr_en_a) begin mem_a[wp_a % 32] <= wr_data_a; wp_a <= wp_a + 1; end
        if (rd_a && (wp_a != rp_a)) begin fifo_data_a <= mem_a[rp_a % 32]; rp_a <= rp_a + 1; end
        if (wr_en_b) begin mem_b[wp_b % 32] <= wr_data_b; wp_b <= wp_b + 1; end
        if (rd_b && (wp_b != rp_b)) begin fifo_data_b <= mem_b[rp_b % 32]; rp_b <= rp_b + 1; end
    end

    // Sample outputs mid-cycle; index = number of the edge that produced them
    always @(negedge clk) begin
        if (cyc < LOGN) begin
            log_a[cyc] <= {tx_a, rd_a, done_a, busy_a};
            log_b[cyc] <= {tx_b, rd_b, done_b, busy_b};
        end
    end

    // Expected {tx, read_en, frame_done, busy} at clock i for n queued bytes
    // that became visible to an idle transmitter after edge w. Each frame
    // takes 10*c bit clocks plus the POP and LOAD clocks ahead of it.
    function automatic logic [3:0] model(input int i, input int w, input int c, input int n);
        int   rel, per, f, p, q, b;
        logic line;
        rel = i - (w + 1);
        per = 10 * c + 2;
        if (rel < 0 || n == 0) return 4'b1000;
        f = rel / per;
        if (f >= n) return 4'b1000;
        p = rel % per;
        if (p == 0) return 4'b1101;
        if (p == 1) return 4'b1001;
        q = p - 2;
        b = q / c;
        if (b == 0)      line = 1'b0;
        else if (b == 9) line = 1'b1;
        else             line = burst[f][b-1];
        return {line, 1'b0, (q == 10 * c - 1), 1'b1};
    endfunction

    function automatic logic [3:0] logged(input int sel, input int k);
        if (k < 0 || k >= LOGN) return 4'bxxxx;
        return (sel != 0) ? log_b[k] : log_a[k];
    endfunction

    task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
    endtask

    // Write one byte; returns the clock edge at which it lands in the FIFO
    task automatic push(input int sel, input logic [7:0] b, output int edge_no);
        edge_no = cyc + 1;
        if (sel != 0) begin wr_en_b = 1'b1; wr_data_b = b; end
        else          begin wr_en_a = 1'b1; wr_data_a = b; end
        @(negedge clk);
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
    endtask

    task automatic wait_past(input int k);
        while (cyc <= k + 1) @(negedge clk);
    endtask

    task automatic check_window(input string tag, input int sel, input int w, input int c,
                                input int n, input int lo, input int hi);
        wait_past(hi);
        for (int i = lo; i <= hi; i++) check(tag, i, logged(sel, i), model(i, w, c, n));
    endtask

    // Count strobes in the log and recover bytes by mid-bit sampling
    task automatic check_frames(input string tag, input int sel, input int c, input int n,
                                input int lo, input int hi);
        int nr, nd, k, found;
        logic [8:0] got;
        nr = 0;
        nd = 0;
        for (int i = lo; i <= hi; i++) begin
            if (logged(sel, i) [2] === 1'b1) nr++;
            if (logged(sel, i) [1] === 1'b1) nd++;
        end
        check({tag, "_reads"}, 0, nr, n);
        check({tag, "_dones"}, 0, nd, n);
        k = lo;
        for (int f = 0; f < n; f++) begin
            found = -1;
            while (found < 0 && k <= hi) begin
                if (logged(sel, k) [3] === 1'b0) found = k;
                k++;
            end
            check({tag, "_start_found"}, f, (found >= 0), 1);
            if (found < 0) found = hi;
            for (int b = 0; b < 9; b++) got[b] = logged(sel, found + c * (b + 1) + c / 2) [3];
            check({tag, "_byte"}, f, got, {1'b1, burst[f]});
            k = found + 10 * c;
        end
    endtask

    initial begin
        int w, r, s, hi;

        // 1: reset held while the FIFO already has data
        @(negedge clk);
        burst[0] = 8'($urandom);
        push(0, burst[0], w);
        @(negedge clk);
        r = cyc;
        rst_a = 1'b1;
        rst_b = 1'b1;
        hi = r + 1 + 42 + 4;
        check_window("reset_release", 0, r, CA, 1, 1, hi);
        check_frames("reset_release", 0, CA, 1, r, hi);

        // 2: single byte 0x2C
        burst[0] = 8'h2C;
        push(0, burst[0], w);
        hi = w + 1 + 42 + 5;
        check_window("single", 0, w, CA, 1, w, hi);
        check_frames("single", 0, CA, 1, w, hi);
        check("single_fifo_empty", 0, fifo_empty_a, 1'b1);

        // 3: back-to-back preload
        burst[0] = 8'h55;
        burst[1] = 8'hA3;
        burst[2] = 8'hFF;
        push(0, burst[0], w);
        push(0, burst[1], s);
        push(0, burst[2], s);
        hi = w + 1 + 3 * 42 + 5;
        check_window("b2b", 0, w, CA, 3, w, hi);
        check_frames("b2b", 0, CA, 3, w, hi);

        // 3b: random burst
        for (int i = 0; i < 5; i++) burst[i] = 8'($urandom);
        push(0, burst[0], w);
        for (int i = 1; i < 5; i++) push(0, burst[i], s);
        hi = w + 1 + 5 * 42 + 5;
        check_window("rand_burst", 0, w, CA, 5, w, hi);
        check_frames("rand_burst", 0, CA, 5, w, hi);

        // 4: empty FIFO for 200 clocks on both instances
        s = cyc + 1;
        hi = s + 199;
        check_window("empty_a", 0, 0, CA, 0, s, hi);
        check_window("empty_b", 1, 0, CB, 0, 1, hi);

        // 5: reset during data bit 3 of 0x0F, two more bytes queued
        burst[0] = 8'h0F;
        burst[1] = 8'($urandom);
        burst[2] = 8'($urandom);
        push(0, burst[0], w);
        push(0, burst[1], s);
        push(0, burst[2], s);
        r = (w + 3) + 4 * CA + 1;
        while (cyc < r - 1) @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        check_window("pre_abort", 0, w, CA, 3, w, r - 1);
        burst[0] = burst[1];
        burst[1] = burst[2];
        hi = r + 1 + 2 * 42 + 5;
        check_window("post_abort", 0, r, CA, 2, r, hi);
        check_frames("post_abort", 0, CA, 2, r, hi);
        check("post_abort_fifo_empty", 0, fifo_empty_a, 1'b1);

        // 6: full 16-entry drain at two clocks per bit
        for (int i = 0; i < 16; i++) burst[i] = 8'(i);
        push(1, burst[0], w);
        for (int i = 1; i < 16; i++) push(1, burst[i], s);
        hi = w + 1 + 16 * 22 + 5;
        check_window("drain", 1, w, CB, 16, w, hi);
        check_frames("drain", 1, CB, 16, w, hi);
        check("drain_fifo_empty", 0, fifo_empty_b, 1'b1);
        check("drain_busy", 0, busy_b, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial transmit stage sitting directly downstream of the UART TX FIFO that the memory map fills via MMIO address 0xFFFFFFFF. Pops one word at a time from the FIFO read port and shifts it out on a single TX line as 8N1 frames: 1 start bit, DATA_WIDTH data bits LSB-first, 1 stop bit. Drains the FIFO back-to-back while it is non-empty and idles with the line high otherwise.

Parameters:
DATA_WIDTH, 8, payload bits per frame; matches the FIFO data width.
CLKS_PER_BIT, 868, clk cycles per bit period (100 MHz / 115200); legal range 2..65535.
CNT_WIDTH, 16, width of the bit-period counter; must satisfy 2^CNT_WIDTH > CLKS_PER_BIT.

Ports:
clk  in  1  system clock, all logic on the rising edge
rst  in  1  synchronous, active-low reset (0 = reset)
fifo_data  in  DATA_WIDTH  FIFO data_out; valid one cycle after fifo_read_en is asserted
fifo_empty  in  1  FIFO empty_out
fifo_read_en  out  1  FIFO read_en_in; single-cycle pop strobe
tx  out  1  serial line; idle high
busy  out  1  high from pop strobe until stop bit completes
frame_done  out  1  one-cycle pulse on the last cycle of each stop bit

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, tx=1, busy=0, fifo_read_en=0, frame_done=0, counters and shift register cleared. Applies mid-frame: the frame is aborted, tx returns high on the next edge, and the popped byte is lost. No re-pop occurs.
- States: IDLE, POP, LOAD, START, DATA, STOP.
- IDLE: if fifo_empty=0, go to POP. Otherwise stay; tx=1.
- POP: assert fifo_read_en for exactly this one cycle, set busy=1, then go to LOAD.
- LOAD: capture fifo_data into the shift register, then go to START. fifo_read_en=0.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. The bit index runs 0..DATA_WIDTH-1.
- STOP: tx=1 for CLKS_PER_BIT cycles. On the last cycle, pulse frame_done=1. Then:
  - if fifo_empty=0, go to POP;
  - otherwise go to IDLE and drop busy to 0.
- Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary and on every state entry.
- tx, busy, fifo_read_en and frame_done are registered outputs. No combinational path from inputs.
- Latency: IDLE with FIFO non-empty → falling edge of the start bit appears 3 clk edges later (POP, LOAD, START entry).
- Frame length: (DATA_WIDTH+2)*CLKS_PER_BIT cycles. Back-to-back gap (stop end to next start) is exactly 2 cycles (POP, LOAD) of tx=1.
- fifo_read_en is never asserted when fifo_empty=1 in the same cycle, so the FIFO is never underflowed.
- Simultaneous FIFO write while in STOP with the FIFO empty is sampled at the STOP exit cycle. If empty has deasserted by then, go straight to POP.
- The block never reads fifo_data outside LOAD. FIFO contents changing at other times are ignored.

Decomposition:
- Shared package uart_pkg:
  - enum uart_tx_state_t {IDLE, POP, LOAD, START, DATA, STOP};
  - localparam UART_IDLE_LEVEL = 1'b1;
  - default CLKS_PER_BIT constant, reused by the future uart_rx.
- One natural sub-module: uart_baud_cnt, the bit-period counter.
  - Inputs: clk, rst, clear.
  - Output: tick, high on count == CLKS_PER_BIT-1.
  - Shared with uart_rx.

Test Plan (CLKS_PER_BIT=4 unless noted):
1. Reset: hold rst=0 for 2 cycles → tx=1, busy=0, fifo_read_en=0 while the FIFO holds data. Release rst → pop occurs on the next edge.
2. Single byte: write 0x2C (44) through memmap to 0xFFFFFFFF →
   - one fifo_read_en pulse;
   - tx sequence 0,0,0,1,1,0,1,0,0,1 (start, LSB-first, stop), each held 4 cycles;
   - frame_done pulses once; busy=0 afterwards; FIFO empty.
3. Back-to-back: preload 0x55, 0xA3, 0xFF →
   - three frames of 40 cycles each;
   - exactly 2 idle-high cycles between frames;
   - three fifo_read_en pulses total;
   - the decoded bytes match.
4. Empty FIFO: run 200 cycles with nothing written → fifo_read_en never asserted, tx constant 1, busy 0.
5. Reset mid-frame: assert rst=0 during data bit 3 of 0x0F → tx=1 on the next edge, state IDLE. The FIFO's remaining entries are transmitted intact after release.
6. Full FIFO drain with CLKS_PER_BIT=2: fill 16 entries 0x00..0x0F → 16 frames in order, then fifo_empty=1, busy=0, 16 frame_done pulses.
